// File: rtl/icb_arb2_outs.sv
// Two-master ICB arbiter: round-robin command grant with hold-until-accepted lock,
// in-order ID FIFO of granted masters, and combinational response routing.
module icb_arb2_outs #(
    parameter int AW   = 64,
    parameter int DW   = 64,
    parameter int OUTS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              m_icb_cmd_valid,
    output logic [1:0]              m_icb_cmd_ready,
    input  logic [2*AW-1:0]         m_icb_cmd_addr,
    input  logic [1:0]              m_icb_cmd_read,
    input  logic [2*DW-1:0]         m_icb_cmd_wdata,
    input  logic [2*(DW/8)-1:0]     m_icb_cmd_wmask,
    output logic [1:0]              m_icb_rsp_valid,
    input  logic [1:0]              m_icb_rsp_ready,
    output logic [2*DW-1:0]         m_icb_rsp_rdata,
    output logic [1:0]              m_icb_rsp_err,
    output logic                    s_icb_cmd_valid,
    input  logic                    s_icb_cmd_ready,
    output logic [AW-1:0]           s_icb_cmd_addr,
    output logic                    s_icb_cmd_read,
    output logic [DW-1:0]           s_icb_cmd_wdata,
    output logic [DW/8-1:0]         s_icb_cmd_wmask,
    input  logic                    s_icb_rsp_valid,
    output logic                    s_icb_rsp_ready,
    input  logic [DW-1:0]           s_icb_rsp_rdata,
    input  logic                    s_icb_rsp_err,
    output logic [$clog2(OUTS):0]   outs_cnt
);
    localparam int PW = $clog2(OUTS);
    localparam int CW = PW + 1;
    localparam int MW = DW / 8;

    logic          rr_ptr_reg;
    logic          lock_reg;
    logic          lock_id_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] cnt_reg;
    logic          id_mem [OUTS];

    logic grant;
    logic full;
    logic empty;
    logic head;
    logic push;
    logic pop;

    // A pending (unaccepted) command keeps its grant so nothing switches mid-handshake.
    always_comb begin
        grant = rr_ptr_reg;
        if (lock_reg)
            grant = lock_id_reg;
        else if (m_icb_cmd_valid == 2'b01)
            grant = 1'b0;
        else if (m_icb_cmd_valid == 2'b10)
            grant = 1'b1;
    end

    assign full  = (cnt_reg == CW'(OUTS));
    assign empty = (cnt_reg == '0);
    assign head  = id_mem[rd_ptr_reg];

    assign s_icb_cmd_valid = (|m_icb_cmd_valid) & ~full & ~rst;
    assign s_icb_cmd_addr  = grant ? m_icb_cmd_addr[AW +: AW]  : m_icb_cmd_addr[0 +: AW];
    assign s_icb_cmd_wdata = grant ? m_icb_cmd_wdata[DW +: DW] : m_icb_cmd_wdata[0 +: DW];
    assign s_icb_cmd_wmask = grant ? m_icb_cmd_wmask[MW +: MW] : m_icb_cmd_wmask[0 +: MW];
    assign s_icb_cmd_read  = m_icb_cmd_read[grant];

    assign s_icb_rsp_ready = ~empty & m_icb_rsp_ready[head];

    assign push = s_icb_cmd_valid & s_icb_cmd_ready;
    assign pop  = s_icb_rsp_valid & s_icb_rsp_ready;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign m_icb_cmd_ready[gi]          = s_icb_cmd_ready & ~full & ~rst & (grant == 1'(gi));
            assign m_icb_rsp_valid[gi]          = s_icb_rsp_valid & ~empty & (head == 1'(gi));
            assign m_icb_rsp_rdata[gi*DW +: DW] = s_icb_rsp_rdata;
            assign m_icb_rsp_err[gi]            = s_icb_rsp_err;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg  <= 1'b0;
            lock_reg    <= 1'b0;
            lock_id_reg <= 1'b0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            cnt_reg     <= '0;
        end else begin
            if (push) begin
                rr_ptr_reg <= ~grant;
                lock_reg   <= 1'b0;
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end else if (s_icb_cmd_valid) begin
                lock_reg    <= 1'b1;
                lock_id_reg <= grant;
            end
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   cnt_reg <= cnt_reg + 1'b1;
                2'b01:   cnt_reg <= cnt_reg - 1'b1;
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

    // Entries are only read while counted valid, so the ID storage needs no reset.
    always_ff @(posedge clk) begin
        if (push)
            id_mem[wr_ptr_reg] <= grant;
    end

    assign outs_cnt = cnt_reg;
endmodule

// File: tb/tb_icb_arb2_outs.sv
// Bench for icb_arb2_outs: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_icb_arb2_outs;
    localparam int OUTS = 4;

    logic          clk;
    logic          rst;
    logic [1:0]    mv;
    logic [1:0]    mcr;
    logic [127:0]  maddr;
    logic [1:0]    mrd;
    logic [127:0]  mwd;
    logic [15:0]   mwm;
    logic [1:0]    mrv;
    logic [1:0]    mrr;
    logic [127:0]  mrdata;
    logic [1:0]    merr;
    logic          scv;
    logic          scr;
    logic [63:0]   saddr;
    logic          sread;
    logic [63:0]   swd;
    logic [7:0]    swm;
    logic          srv;
    logic          srr;
    logic [63:0]   srd;
    logic          serr;
    logic [2:0]    cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit armed = 0;

    int q[$];
    int pref = 0;
    int held = -1;
    int glog[$];
    int rlog[$];

    icb_arb2_outs #(.AW(64), .DW(64), .OUTS(OUTS)) dut (
        .clk(clk), .rst(rst),
        .m_icb_cmd_valid(mv), .m_icb_cmd_ready(mcr), .m_icb_cmd_addr(maddr),
        .m_icb_cmd_read(mrd), .m_icb_cmd_wdata(mwd), .m_icb_cmd_wmask(mwm),
        .m_icb_rsp_valid(mrv), .m_icb_rsp_ready(mrr), .m_icb_rsp_rdata(mrdata),
        .m_icb_rsp_err(merr),
        .s_icb_cmd_valid(scv), .s_icb_cmd_ready(scr), .s_icb_cmd_addr(saddr),
        .s_icb_cmd_read(sread), .s_icb_cmd_wdata(swd), .s_icb_cmd_wmask(swm),
        .s_icb_rsp_valid(srv), .s_icb_rsp_ready(srr), .s_icb_rsp_rdata(srd),
        .s_icb_rsp_err(serr), .outs_cnt(cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Who the arbiter must be serving: the holder of a refused offer, a sole requester, or the preferred one.
    function automatic int mgrant();
        if (held >= 0) return held;
        if (mv == 2'b01) return 0;
        if (mv == 2'b10) return 1;
        return pref;
    endfunction

    function automatic bit mscv();
        return (mv != 2'b00) && (q.size() < OUTS) && !rst;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            pref = 0;
            held = -1;
        end else begin
            int g;
            bit v;
            bit popm;
            g = mgrant();
            v = mscv();
            popm = (q.size() > 0) && srv && mrr[q[0]];
            if (popm) void'(q.pop_front());
            if (v && scr) begin
                q.push_back(g);
                pref = 1 - g;
                held = -1;
            end else if (v) begin
                held = g;
            end
        end
    end

    always @(negedge clk) begin
        int g;
        bit e_scv;
        logic [1:0] e_cr;
        logic [1:0] e_rv;
        logic e_srr;
        if (armed) begin
            g = mgrant();
            e_scv = mscv();
            e_cr = (scr && q.size() < OUTS && !rst) ? 2'(2'b01 << g) : 2'b00;
            e_rv = 2'b00;
            e_srr = 1'b0;
            if (q.size() > 0) begin
                e_rv = srv ? 2'(2'b01 << q[0]) : 2'b00;
                e_srr = mrr[q[0]];
            end
            check("s_cmd_valid", 64'(scv), 64'(e_scv));
            check("m_cmd_ready", 64'(mcr), 64'(e_cr));
            if (e_scv) begin
                check("s_cmd_addr", saddr, maddr[g*64 +: 64]);
                check("s_cmd_wdata", swd, mwd[g*64 +: 64]);
                check("s_cmd_wmask", 64'(swm), 64'(mwm[g*8 +: 8]));
                check("s_cmd_read", 64'(sread), 64'(mrd[g]));
            end
            check("m_rsp_valid", 64'(mrv), 64'(e_rv));
            check("s_rsp_ready", 64'(srr), 64'(e_srr));
            check("outs_cnt", 64'(cnt), 64'(q.size()));
            check("m0_rdata", mrdata[63:0], srd);
            check("m1_rdata", mrdata[127:64], srd);
            check("m_rsp_err", 64'(merr), 64'({serr, serr}));
            if (scv && scr) begin
                glog.push_back(int'(mcr[1]));
                $display("cmd  master=%0d addr=%h read=%0d outs=%0d", mcr[1], saddr, sread, cnt);
            end
            if (srv && srr) begin
                rlog.push_back(int'(mrv[1]));
                $display("rsp  master=%0d rdata=%h err=%0d outs=%0d", mrv[1], srd, serr, cnt);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mv = 2'b00; mrd = 2'b00; maddr = '0; mwd = '0; mwm = '0; mrr = 2'b00;
        scr = 1'b0; srv = 1'b0; srd = '0; serr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        // Reset gating: busy inputs must not leak through while reset is held.
        mv = 2'b11; scr = 1'b1; srv = 1'b1; mrr = 2'b11;
        step();
        armed = 1'b1;
        check("rst_outs_cnt", 64'(cnt), 64'd0);
        check("rst_s_cmd_valid", 64'(scv), 64'd0);
        check("rst_m_cmd_ready", 64'(mcr), 64'd0);
        check("rst_s_rsp_ready", 64'(srr), 64'd0);
        check("rst_m_rsp_valid", 64'(mrv), 64'd0);
        idle_inputs();
        step();
        rst = 1'b0;
        step();

        // 1: single master write
        mv = 2'b01; mrd = 2'b00; maddr[63:0] = 64'h10; mwd[63:0] = 64'hA5; mwm[7:0] = 8'hFF; scr = 1'b1;
        #1;
        check("t1_s_cmd_valid", 64'(scv), 64'd1);
        check("t1_s_cmd_addr", saddr, 64'h10);
        check("t1_s_cmd_wdata", swd, 64'hA5);
        check("t1_s_cmd_wmask", 64'(swm), 64'hFF);
        check("t1_m_cmd_ready", 64'(mcr), 64'b01);
        step();
        mv = 2'b00;
        #1;
        check("t1_outs_after_cmd", 64'(cnt), 64'd1);
        srv = 1'b1; mrr = 2'b11; serr = 1'b0;
        #1;
        check("t1_m_rsp_valid", 64'(mrv), 64'b01);
        check("t1_m_rsp_err", 64'(merr), 64'd0);
        step();
        srv = 1'b0;
        #1;
        check("t1_outs_after_rsp", 64'(cnt), 64'd0);

        // 2: contention, alternating grants
        idle_inputs();
        do_reset();
        glog.delete(); rlog.delete();
        maddr = {64'h2000, 64'h1000}; mrd = 2'b11;
        mv = 2'b11; scr = 1'b1; srv = 1'b1; mrr = 2'b11;
        for (int i = 0; i < 6; i++) begin
            srd = 64'hD0 + 64'(i);
            step();
        end
        mv = 2'b00;
        step();
        srv = 1'b0;
        step();
        check("t2_grant_count", 64'(glog.size()), 64'd6);
        check("t2_rsp_count", 64'(rlog.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < glog.size()) check("t2_grant_order", 64'(glog[i]), 64'(i % 2));
            if (i < rlog.size()) check("t2_rsp_route", 64'(rlog[i]), 64'(i % 2));
        end

        // 3: grant held through a slave stall
        glog.delete();
        maddr = {64'h200, 64'h100}; mrd = 2'b00;
        srv = 1'b1; mrr = 2'b11;
        mv = 2'b11; scr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_stall_addr", saddr, 64'h100);
            check("t3_stall_ready", 64'(mcr), 64'd0);
            step();
        end
        scr = 1'b1;
        #1;
        check("t3_m0_accept", 64'(mcr), 64'b01);
        step();
        check("t3_m1_next", 64'(mcr), 64'b10);
        step();
        mv = 2'b10; scr = 1'b0;
        step();
        mv = 2'b11;
        #1;
        check("t3_lock_overrides_rr", saddr, 64'h200);
        step();
        scr = 1'b1;
        step();
        #1;
        check("t3_m0_after_lock", 64'(mcr), 64'b01);
        step();
        mv = 2'b00;
        step();
        step();
        srv = 1'b0;
        check("t3_grant_count", 64'(glog.size()), 64'd4);
        if (glog.size() == 4) begin
            check("t3_g0", 64'(glog[0]), 64'd0);
            check("t3_g1", 64'(glog[1]), 64'd1);
            check("t3_g2", 64'(glog[2]), 64'd1);
            check("t3_g3", 64'(glog[3]), 64'd0);
        end

        // 4: fill to OUTS with no responses
        mv = 2'b01; scr = 1'b1; srv = 1'b0; mrr = 2'b01;
        for (int i = 0; i < 4; i++) begin
            maddr[63:0] = 64'h400 + 64'(i);
            step();
        end
        maddr[63:0] = 64'h404;
        check("t4_outs_full", 64'(cnt), 64'd4);
        check("t4_full_valid", 64'(scv), 64'd0);
        check("t4_full_ready", 64'(mcr), 64'd0);
        step();
        check("t4_still_stalled", 64'(scv), 64'd0);
        srv = 1'b1; srd = 64'h55;
        #1;
        check("t4_pop_ready", 64'(srr), 64'd1);
        check("t4_no_push_on_pop", 64'(scv), 64'd0);
        step();
        check("t4_freed_valid", 64'(scv), 64'd1);
        check("t4_outs_freed", 64'(cnt), 64'd3);
        step();
        check("t4_push_pop_at_3", 64'(cnt), 64'd3);
        srv = 1'b0;
        step();
        check("t4_refilled", 64'(cnt), 64'd4);
        mv = 2'b00; srv = 1'b1;
        repeat (4) step();
        srv = 1'b0;
        check("t4_drained", 64'(cnt), 64'd0);

        // 5: head-of-line response backpressure
        mv = 2'b10; scr = 1'b1;
        step();
        mv = 2'b01;
        step();
        mv = 2'b00;
        rlog.delete();
        srv = 1'b1; srd = 64'hBEEF; mrr = 2'b01;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t5_s_rsp_ready", 64'(srr), 64'd0);
            check("t5_m_rsp_valid", 64'(mrv), 64'b10);
            check("t5_outs", 64'(cnt), 64'd2);
            step();
        end
        mrr = 2'b11;
        step();
        step();
        srv = 1'b0;
        check("t5_outs_end", 64'(cnt), 64'd0);
        check("t5_rsp_count", 64'(rlog.size()), 64'd2);
        if (rlog.size() == 2) begin
            check("t5_first_m1", 64'(rlog[0]), 64'd1);
            check("t5_then_m0", 64'(rlog[1]), 64'd0);
        end

        // 6: asynchronous reset mid-traffic
        mv = 2'b01; scr = 1'b1; srv = 1'b0;
        repeat (3) step();
        mv = 2'b10; scr = 1'b0;
        step();
        check("t6_outs_before", 64'(cnt), 64'd3);
        srv = 1'b1; mrr = 2'b11;
        rst = 1'b1;
        #1;
        check("t6_outs_cnt", 64'(cnt), 64'd0);
        check("t6_s_cmd_valid", 64'(scv), 64'd0);
        check("t6_m_cmd_ready", 64'(mcr), 64'd0);
        check("t6_m_rsp_valid", 64'(mrv), 64'd0);
        check("t6_s_rsp_ready", 64'(srr), 64'd0);
        step();
        rst = 1'b0; srv = 1'b0; mv = 2'b11; scr = 1'b1;
        #1;
        check("t6_resume_grant", 64'(mcr), 64'b01);
        step();
        mv = 2'b00;
        check("t6_resume_outs", 64'(cnt), 64'd1);
        srv = 1'b1;
        step();
        srv = 1'b0;
        check("t6_resume_drain", 64'(cnt), 64'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
